// File: rtl/sw_stim_gen.sv
// Purpose : pattern-driven switch stimulus source (HOLD/COUNT/WALK1/LFSR/SEQ) with hold period and pause.
// Latency : first value appears 1 cycle after the enabling edge; each value is held for `period` RUN cycles.
// Backpress: none downstream; i_en low pauses (data and hold count frozen), i_restart returns to IDLE.
//
// Ports:
//   i_clk, i_reset (sync, active-low)   clock / reset
//   i_en, i_restart                      run enable / synchronous return to IDLE
//   i_mode, i_init, i_step               pattern select, start value, COUNT increment
//   i_hold_cycles, i_seq_len             hold period (0 -> 1), SEQ length (0 -> 1, clamped to SEQ_DEPTH)
//   i_seq_we, i_seq_waddr, i_seq_wdata   sequence-table write port (any state)
//   o_sw_data, o_sw_upd, o_wrap          registered stimulus, update pulse, wrap flag
//   o_busy, o_upd_cnt                    RUN/PAUSE indicator, saturating update counter
module sw_stim_gen #(
   parameter int                DATA_W    = 32,
   parameter int                HOLD_W    = 16,
   parameter int                SEQ_DEPTH = 8,
   parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(32'h0000_0001),
   parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003)
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_en,
   input  logic                       i_restart,
   input  logic [2:0]                 i_mode,
   input  logic [DATA_W-1:0]          i_init,
   input  logic [DATA_W-1:0]          i_step,
   input  logic [HOLD_W-1:0]          i_hold_cycles,
   input  logic [$clog2(SEQ_DEPTH):0] i_seq_len,
   input  logic                       i_seq_we,
   input  logic [$clog2(SEQ_DEPTH)-1:0] i_seq_waddr,
   input  logic [DATA_W-1:0]          i_seq_wdata,
   output logic [DATA_W-1:0]          o_sw_data,
   output logic                       o_sw_upd,
   output logic                       o_wrap,
   output logic                       o_busy,
   output logic [31:0]                o_upd_cnt
);

   localparam int AW = $clog2(SEQ_DEPTH);
   localparam int LW = AW + 1;
   // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
   localparam logic [DATA_W-1:0] SEED = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;
   typedef enum logic [2:0] {M_HOLD = 3'd0, M_COUNT = 3'd1, M_WALK1 = 3'd2,
                             M_LFSR = 3'd3, M_SEQ = 3'd4} mode_e;

   state_e             state, state_nxt;
   mode_e              mode_l, mode_in;
   logic [DATA_W-1:0]  step_l;
   logic [HOLD_W-1:0]  period_l, period_in, hold_cnt;
   logic [LW-1:0]      len_l, len_in;
   logic [AW-1:0]      idx, adv_idx;
   logic [DATA_W-1:0]  tbl [SEQ_DEPTH];
   logic [DATA_W-1:0]  first_val, adv_data;
   logic [DATA_W:0]    sum_w;
   logic               adv_wrap, load, step_en, hold_last, adv;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (!i_reset) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step_en   = 1'b0;
      case (state)
         S_IDLE:  if (i_en) begin state_nxt = S_RUN; load = 1'b1; end
         S_RUN:   if (!i_en) state_nxt = S_PAUSE; else step_en = 1'b1;
         S_PAUSE: if (i_en) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
      // Restart wins over everything else and freezes the datapath on its edge.
      if (i_restart) begin
         state_nxt = S_IDLE;
         load      = 1'b0;
         step_en   = 1'b0;
      end
   end

   assign o_busy = (state != S_IDLE);

   // ---------------- control latching ----------------
   always_comb begin
      mode_in   = (i_mode > 3'd4) ? M_HOLD : mode_e'(i_mode);
      period_in = (i_hold_cycles == '0) ? HOLD_W'(1) : i_hold_cycles;
      len_in    = i_seq_len;
      if (i_seq_len == '0)                  len_in = LW'(1);
      else if (i_seq_len > LW'(SEQ_DEPTH))  len_in = LW'(SEQ_DEPTH);
      case (mode_in)
         M_WALK1: first_val = DATA_W'(1);
         M_LFSR:  first_val = SEED;
         M_SEQ:   first_val = tbl[AW'(0)];
         default: first_val = i_init;
      endcase
   end

   // ---------------- advance rules ----------------
   always_comb begin
      sum_w    = {1'b0, o_sw_data} + {1'b0, step_l};
      adv_data = o_sw_data;
      adv_wrap = 1'b0;
      adv_idx  = idx;
      case (mode_l)
         M_COUNT: begin
            adv_data = sum_w[DATA_W-1:0];
            adv_wrap = sum_w[DATA_W];
         end
         M_WALK1: begin
            if (o_sw_data[DATA_W-1]) begin
               adv_data = DATA_W'(1);
               adv_wrap = 1'b1;
            end else begin
               adv_data = o_sw_data << 1;
            end
         end
         M_LFSR: begin
            adv_data = o_sw_data[0] ? ((o_sw_data >> 1) ^ LFSR_TAPS) : (o_sw_data >> 1);
            adv_wrap = (adv_data == SEED);
         end
         M_SEQ: begin
            if ({1'b0, idx} == len_l - LW'(1)) begin
               adv_idx  = '0;
               adv_wrap = 1'b1;
            end else begin
               adv_idx = idx + AW'(1);
            end
            adv_data = tbl[adv_idx];
         end
         default: ;
      endcase
   end

   assign hold_last = (hold_cnt == period_l - HOLD_W'(1));
   assign adv       = step_en && hold_last && (mode_l != M_HOLD);

   // ---------------- datapath ----------------
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         o_sw_data <= '0;
         o_sw_upd  <= 1'b0;
         o_wrap    <= 1'b0;
         o_upd_cnt <= '0;
         hold_cnt  <= '0;
         idx       <= '0;
         mode_l    <= M_HOLD;
         step_l    <= '0;
         period_l  <= HOLD_W'(1);
         len_l     <= LW'(1);
      end else begin
         o_sw_upd <= 1'b0;
         o_wrap   <= 1'b0;
         if (load) begin
            mode_l    <= mode_in;
            step_l    <= i_step;
            period_l  <= period_in;
            len_l     <= len_in;
            o_sw_data <= first_val;
            idx       <= '0;
            hold_cnt  <= '0;
            o_sw_upd  <= 1'b1;
         end else if (step_en) begin
            if (hold_last) begin
               hold_cnt <= '0;
               if (adv) begin
                  o_sw_data <= adv_data;
                  o_wrap    <= adv_wrap;
                  idx       <= adv_idx;
                  o_sw_upd  <= 1'b1;
               end
            end else begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
            end
         end
         if ((load || adv) && (o_upd_cnt != '1))
            o_upd_cnt <= o_upd_cnt + 32'd1;
      end
   end

   // Table reads above see the pre-edge contents, so a same-edge write is not visible yet.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         for (int i = 0; i < SEQ_DEPTH; i++) tbl[i] <= '0;
      end else if (i_seq_we) begin
         tbl[i_seq_waddr] <= i_seq_wdata;
      end
   end

endmodule

// File: tb/tb_sw_stim_gen.sv
// Purpose : self-checking bench for sw_stim_gen with an expectation queue and a decoupled monitor.
// Latency : monitor checks every o_sw_upd pulse (value, wrap flag, spacing) as it appears.
// Backpress: stimulus waits, with a cycle budget, for the queue to drain before restarting.
module tb_sw_stim_gen;

   logic        i_clk = 1'b0;
   logic        i_reset, i_en, i_restart, i_seq_we;
   logic [2:0]  i_mode;
   logic [31:0] i_init, i_step, i_seq_wdata;
   logic [15:0] i_hold_cycles;
   logic [3:0]  i_seq_len;
   logic [2:0]  i_seq_waddr;
   logic [31:0] o_sw_data, o_upd_cnt;
   logic        o_sw_upd, o_wrap, o_busy;

   sw_stim_gen dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_restart(i_restart),
      .i_mode(i_mode), .i_init(i_init), .i_step(i_step),
      .i_hold_cycles(i_hold_cycles), .i_seq_len(i_seq_len),
      .i_seq_we(i_seq_we), .i_seq_waddr(i_seq_waddr), .i_seq_wdata(i_seq_wdata),
      .o_sw_data(o_sw_data), .o_sw_upd(o_sw_upd), .o_wrap(o_wrap),
      .o_busy(o_busy), .o_upd_cnt(o_upd_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] data;
      logic        wrap;
      int          gap;   // required cycles since previous update; 0 = not checked
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          last_upd_cyc = 0;
   int          exp_cnt  = 0;
   logic [31:0] last_data = 32'd0;
   logic [31:0] tbl_m [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge i_clk) begin
      exp_t e;
      if (o_sw_upd === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_upd: got data %h, required no update", o_sw_data);
         end else begin
            e = exp_q.pop_front();
            chk("upd_data", o_sw_data, e.data);
            chk("upd_wrap", {31'd0, o_wrap}, {31'd0, e.wrap});
            if (e.gap != 0) chk("upd_gap", 32'(cyc - last_upd_cyc), 32'(e.gap));
         end
         last_upd_cyc = cyc;
      end
      cyc++;
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] cnt_val(input longint unsigned init, input longint unsigned step, input int k);
      longint unsigned v = init + longint'(k) * step;
      return v[31:0];
   endfunction

   function automatic logic cnt_wrap(input longint unsigned init, input longint unsigned step, input int k);
      longint unsigned a = init + longint'(k) * step;
      longint unsigned b = init + longint'(k - 1) * step;
      return (k > 0) && ((a >> 32) != (b >> 32));
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      logic [31:0] taps = 32'h8020_0003;
      return x[0] ? ((x >> 1) ^ taps) : (x >> 1);
   endfunction

   task automatic push(input logic [31:0] d, input logic w, input int gap);
      exp_t e;
      e.data = d; e.wrap = w; e.gap = gap;
      exp_q.push_back(e);
      exp_cnt++;
      last_data = d;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge i_clk);
      #1;
   endtask

   task automatic tbl_write(input int a, input logic [31:0] d);
      i_seq_we = 1'b1; i_seq_waddr = 3'(a); i_seq_wdata = d;
      tick();
      i_seq_we = 1'b0;
      tbl_m[a] = d;
   endtask

   task automatic reset_pulse();
      i_en = 1'b0; i_restart = 1'b0; i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      exp_cnt = 0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) tbl_m[i] = 32'd0;
   endtask

   task automatic start(input logic [2:0] mode, input logic [31:0] init, input logic [31:0] step,
                        input logic [15:0] hold, input logic [3:0] len);
      i_mode = mode; i_init = init; i_step = step; i_hold_cycles = hold; i_seq_len = len;
      i_en = 1'b1;
   endtask

   task automatic drain(input bit scramble);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         n++;
         if (scramble) begin
            i_mode        = 3'($urandom_range(0, 7));
            i_step        = $urandom;
            i_init        = $urandom;
            i_hold_cycles = 16'($urandom_range(0, 7));
            i_seq_len     = 4'($urandom_range(0, 15));
         end
      end
      chk("run_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic run_and_stop(input bit scramble);
      drain(scramble);
      i_restart = 1'b1; i_en = 1'b0;
      tick();
      chk("restart_busy", {31'd0, o_busy}, 32'd0);
      chk("restart_upd", {31'd0, o_sw_upd}, 32'd0);
      chk("restart_data_held", o_sw_data, last_data);
      chk("upd_cnt", o_upd_cnt, 32'(exp_cnt));
      i_restart = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] v;
      int          n;
      int          len_e, per;
      logic [31:0] init_r, step_r;
      logic [15:0] hold_r;
      logic [3:0]  len_r;

      i_reset = 1'b0; i_en = 1'b1; i_restart = 1'b0; i_mode = 3'd1;
      i_init = 32'h1234; i_step = 32'd1; i_hold_cycles = 16'd1; i_seq_len = 4'd1;
      i_seq_we = 1'b0; i_seq_waddr = 3'd0; i_seq_wdata = 32'd0;
      for (int i = 0; i < 8; i++) tbl_m[i] = 32'd0;

      // Reset held with enable high: everything stays cleared.
      repeat (5) tick();
      chk("reset_data", o_sw_data, 32'd0);
      chk("reset_busy", {31'd0, o_busy}, 32'd0);
      chk("reset_cnt", o_upd_cnt, 32'd0);
      chk("reset_upd", {31'd0, o_sw_upd}, 32'd0);
      chk("reset_wrap", {31'd0, o_wrap}, 32'd0);
      i_en = 1'b0; i_reset = 1'b1;
      tick();
      chk("idle_busy", {31'd0, o_busy}, 32'd0);

      // Reset in the middle of a run; also clears the sequence table.
      tbl_write(0, 32'h55);
      start(3'd1, 32'd5, 32'd3, 16'd2, 4'd1);
      for (int k = 0; k < 3; k++) push(cnt_val(5, 3, k), cnt_wrap(5, 3, k), (k == 0) ? 0 : 2);
      drain(1'b0);
      i_reset = 1'b0;
      tick();
      chk("midrun_reset_data", o_sw_data, 32'd0);
      chk("midrun_reset_busy", {31'd0, o_busy}, 32'd0);
      chk("midrun_reset_cnt", o_upd_cnt, 32'd0);
      chk("midrun_reset_upd", {31'd0, o_sw_upd}, 32'd0);
      i_en = 1'b0; i_reset = 1'b1;
      exp_cnt = 0;
      for (int i = 0; i < 8; i++) tbl_m[i] = 32'd0;
      start(3'd4, 32'd0, 32'd0, 16'd1, 4'd1);
      push(tbl_m[0], 1'b0, 0);
      push(tbl_m[0], 1'b1, 1);
      run_and_stop(1'b0);

      // COUNT across the carry-out boundary.
      reset_pulse();
      start(3'd1, 32'hFFFF_FFFE, 32'd1, 16'd2, 4'd1);
      for (int k = 0; k < 3; k++)
         push(cnt_val(32'hFFFF_FFFE, 1, k), cnt_wrap(32'hFFFF_FFFE, 1, k), (k == 0) ? 0 : 2);
      run_and_stop(1'b0);

      // WALK1 with hold 0 (one update per cycle) through a full wrap, controls scrambled mid-run.
      start(3'd2, 32'd0, 32'd0, 16'd0, 4'd1);
      for (int k = 0; k < 33; k++) begin
         v = 32'd1;
         push(v << (k % 32), (k == 32), (k == 0) ? 0 : 1);
      end
      run_and_stop(1'b1);

      // SEQ with a pause while the second entry is shown.
      tbl_write(0, 32'hA); tbl_write(1, 32'hB); tbl_write(2, 32'hC);
      start(3'd4, 32'd0, 32'd0, 16'd3, 4'd3);
      push(32'hA, 1'b0, 0);
      push(32'hB, 1'b0, 3);
      push(32'hC, 1'b0, 0);
      push(32'hA, 1'b1, 3);
      n = 0;
      while (exp_q.size() > 2 && n < 100) begin tick(); n++; end
      i_en = 1'b0;
      repeat (4) begin
         tick();
         chk("pause_data", o_sw_data, 32'hB);
         chk("pause_upd", {31'd0, o_sw_upd}, 32'd0);
         chk("pause_busy", {31'd0, o_busy}, 32'd1);
      end
      i_en = 1'b1;
      run_and_stop(1'b0);

      // LFSR from seed 1, one update per cycle.
      start(3'd3, 32'd0, 32'd0, 16'd1, 4'd1);
      v = 32'd1;
      for (int k = 0; k < 20; k++) begin
         push(v, (k > 0) && (v == 32'd1), (k == 0) ? 0 : 1);
         v = lfsr_next(v);
      end
      run_and_stop(1'b1);

      // Restart and enable together: restart wins, then a new mode is latched.
      start(3'd1, 32'd100, 32'd7, 16'd2, 4'd1);
      push(32'd100, 1'b0, 0);
      push(32'd107, 1'b0, 2);
      drain(1'b0);
      i_restart = 1'b1; i_en = 1'b1;
      tick();
      chk("restart_en_busy", {31'd0, o_busy}, 32'd0);
      chk("restart_en_upd", {31'd0, o_sw_upd}, 32'd0);
      chk("restart_en_data", o_sw_data, 32'd107);
      i_restart = 1'b0; i_mode = 3'd2; i_hold_cycles = 16'd1;
      push(32'd1, 1'b0, 0);
      push(32'd2, 1'b0, 1);
      run_and_stop(1'b0);

      // Randomized COUNT runs with controls scrambled mid-run.
      for (int r = 0; r < 6; r++) begin
         init_r = $urandom; step_r = $urandom;
         hold_r = 16'($urandom_range(0, 4));
         per    = (hold_r == 0) ? 1 : int'(hold_r);
         start(3'd1, init_r, step_r, hold_r, 4'd1);
         for (int k = 0; k < 5; k++)
            push(cnt_val(init_r, step_r, k), cnt_wrap(init_r, step_r, k), (k == 0) ? 0 : per);
         run_and_stop(1'b1);
      end

      // Randomized SEQ runs including zero and oversized lengths.
      for (int r = 0; r < 4; r++) begin
         for (int a = 0; a < 8; a++) tbl_write(a, $urandom);
         len_r  = 4'($urandom_range(0, 15));
         len_e  = (len_r == 0) ? 1 : ((len_r > 8) ? 8 : int'(len_r));
         hold_r = 16'($urandom_range(0, 3));
         per    = (hold_r == 0) ? 1 : int'(hold_r);
         start(3'd4, 32'd0, 32'd0, hold_r, len_r);
         for (int k = 0; k <= 2 * len_e; k++)
            push(tbl_m[k % len_e], (k > 0) && (k % len_e == 0), (k == 0) ? 0 : per);
         run_and_stop(1'b1);
      end

      // HOLD and an undefined mode value: one load pulse, then nothing.
      for (int m = 0; m < 2; m++) begin
         start((m == 0) ? 3'd0 : 3'd6, 32'hDEAD_BEEF, 32'd1, 16'd1, 4'd1);
         push(32'hDEAD_BEEF, 1'b0, 0);
         repeat (6) tick();
         run_and_stop(1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sw_stim_gen.md
Name:
sw_stim_gen

Overview:
Parametrised, synthesizable switch-stimulus generator. It is the successor to the bench's fixed switch driver, and it drives `i_io_sw` of `single_cycle`, or any DATA_W-wide input bus. It adds selectable pattern modes, a programmable hold period, pause/resume, a loadable sequence table, and update/wrap reporting for the scoreboard.

Parameters:
- DATA_W, 32, width of the generated data bus.
- HOLD_W, 16, width of the hold-period input.
- SEQ_DEPTH, 8, number of sequence-table entries (power of 2, ≥2).
- LFSR_SEED, 32'h0000_0001, LFSR start value; a value of 0 is replaced by 1.
- LFSR_TAPS, 32'h8020_0003, Galois tap mask (x^32+x^22+x^2+x+1).

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_en  in  1  run enable; low pauses the generator.
- i_restart  in  1  synchronous return to IDLE; sequence table kept.
- i_mode  in  3  pattern mode: 0 HOLD, 1 COUNT, 2 WALK1, 3 LFSR, 4 SEQ; 5-7 behave as HOLD.
- i_init  in  DATA_W  start value for HOLD and COUNT.
- i_step  in  DATA_W  COUNT increment.
- i_hold_cycles  in  HOLD_W  cycles each value is held; 0 is treated as 1.
- i_seq_len  in  $clog2(SEQ_DEPTH)+1  entries used in SEQ mode; 0 is treated as 1; values > SEQ_DEPTH are clamped to SEQ_DEPTH.
- i_seq_we  in  1  sequence-table write strobe.
- i_seq_waddr  in  $clog2(SEQ_DEPTH)  sequence-table write address.
- i_seq_wdata  in  DATA_W  sequence-table write data.
- o_sw_data  out  DATA_W  generated stimulus (registered).
- o_sw_upd  out  1  high in each cycle o_sw_data shows a newly loaded or advanced value.
- o_wrap  out  1  high together with o_sw_upd when the pattern wraps.
- o_busy  out  1  high in RUN or PAUSE.
- o_upd_cnt  out  32  count of o_sw_upd pulses; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (i_reset==0 at a rising edge):
  - state returns to IDLE.
  - o_sw_data, o_sw_upd, o_wrap, o_busy, o_upd_cnt, hold counter and index are all cleared to 0.
  - all sequence entries are cleared to 0.
  - reset overrides every other input.
- FSM states are IDLE, RUN, PAUSE.
- IDLE:
  - o_sw_data keeps its last value.
  - on i_en==1 (and i_restart==0), latch mode, step, period and seq_len, then load the first value and go to RUN.
  - first values: HOLD/COUNT → i_init; WALK1 → 1; LFSR → seed; SEQ → entry 0.
  - o_sw_upd=1 in the first RUN cycle.
- RUN:
  - the hold counter counts 0..period-1, so each value is visible for exactly `period` cycles.
  - at period-1 the value advances, the counter returns to 0, and o_sw_upd pulses for one cycle.
  - i_en==0 → PAUSE; the counter and data freeze and the advance scheduled for that edge is suppressed.
- PAUSE:
  - everything is held.
  - i_en==1 → RUN, resuming the counter from the frozen count.
- i_restart==1 in any state → IDLE next edge with outputs held; i_restart has priority over i_en.
- Latched controls are fixed for the duration of a run; changes to i_mode, i_step, i_hold_cycles or i_seq_len mid-run have no effect until restart.
- Advance rules:
  - HOLD: no advance, no further o_sw_upd after the load.
  - COUNT: data = data + step mod 2^DATA_W; o_wrap=1 when the addition carries out.
  - WALK1: shift left by 1; from bit DATA_W-1 return to 1 with o_wrap=1.
  - LFSR: if data[0], next = (data>>1) ^ TAPS[DATA_W-1:0]; otherwise next = data>>1; o_wrap=1 when next == seed.
  - SEQ: index increments; after len-1 it returns to 0 with o_wrap=1. Table writes are visible on the next read.
- Table writes are accepted in any state; a write to the entry being loaded on the same edge returns the old value.
- With period==1, a value advances every cycle and o_sw_upd stays high continuously.

Test Plan:
1. Reset: i_reset=0 for 5 cycles with i_en=1, mode COUNT → o_sw_data=0, o_busy=0, o_upd_cnt=0, o_sw_upd=0. Repeat with reset asserted mid-RUN → same values next cycle.
2. COUNT, i_init=32'hFFFF_FFFE, step 1, hold 2 → FFFF_FFFE, FFFF_FFFF, 0000_0000, each held 2 cycles; o_wrap=1 only with 0; o_upd_cnt=3.
3. WALK1, hold 0 (treated as 1) → 1, 2, 4 … 8000_0000, then 1 with o_wrap on the 33rd update; o_sw_upd continuously high.
4. SEQ, table {0xA, 0xB, 0xC}, len 3, hold 3 → drop i_en for 4 cycles while 0xB is shown: 0xB is held, o_sw_upd=0. On resume, the remaining hold cycles complete, then 0xC, then 0xA with o_wrap.
5. LFSR, seed 1, hold 1 → 0000_0001, 8020_0003, C030_0002, 6018_0001.
6. i_restart and i_en together during RUN → IDLE with data held, o_busy=0; next cycle with i_en=1 → RUN, new i_mode latched, first value loaded.
